// File: rtl/stream_seq_checker.sv
// Receive-end checker for an incrementing count stream: accepts beats, verifies +1 sequencing, counts errors.
// Define STREAM_CHK_BP_EN to add LFSR-driven pseudo-random backpressure on ready.
module stream_seq_checker #(
  parameter int DATA_W      = 128,
  parameter int NUM_BEATS   = 1024,
  parameter int ERR_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              enable,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [31:0]       beat_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] first_err_got
);

  typedef enum logic [2:0] {IDLE, SYNC, CHECK, DONE, HALT} state_t;

  state_t              state_q;
  logic                ready_q, busy_q, done_q, err_flag_q, resync_q;
  logic [31:0]         beat_cnt_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic [DATA_W-1:0]   first_err_q, expected_q;
  logic                accept, mismatch, last_beat, bp_ok;
  logic [DATA_W-1:0]   data_inc;

  assign accept    = valid && ready_q;
  assign data_inc  = data + DATA_W'(1);
  assign mismatch  = !resync_q && (data != expected_q);
  assign last_beat = (NUM_BEATS != 0) && (beat_cnt_q + 32'd1 == 32'(NUM_BEATS));

`ifdef STREAM_CHK_BP_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = lfsr_q;
    if (state_q == SYNC || state_q == CHECK) lfsr_d = {lfsr_fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (areset || clear) lfsr_q <= 16'hACE1;
    else                 lfsr_q <= lfsr_d;
  end

  // ready is registered from the advanced LFSR so it tracks lfsr[0] of the current cycle
  assign bp_ok = lfsr_d[0];
`else
  assign bp_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (areset || clear) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      resync_q    <= 1'b0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      expected_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= SYNC;
            ready_q <= bp_ok;
            busy_q  <= 1'b1;
          end
        end
        SYNC: begin
          if (accept) begin
            expected_q <= data_inc;
            beat_cnt_q <= 32'd1;
            resync_q   <= 1'b0;
            if (NUM_BEATS == 1) begin
              done_q  <= 1'b1;
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CHECK;
              ready_q <= bp_ok;
            end
          end else if (!enable) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            ready_q <= bp_ok;
          end
        end
        CHECK: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            expected_q <= data_inc;
            resync_q   <= 1'b0;
            if (mismatch) begin
              err_flag_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
              if (!err_flag_q) first_err_q <= data;
            end
            if (last_beat) done_q <= 1'b1;
            if (mismatch && STOP_ON_ERR != 0) begin
              state_q <= HALT;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (last_beat) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              ready_q <= bp_ok;
            end
          end else if (!enable) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            // a ready-low cycle restarts the source, so the next beat reloads without compare
            if (!ready_q) resync_q <= 1'b1;
            ready_q <= bp_ok;
          end
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready         = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_flag      = err_flag_q;
  assign beat_cnt      = beat_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_got = first_err_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker: three parameterisations share one stimulus bus.
module tb_stream_seq_checker;

  logic         clk = 1'b0;
  logic         areset, enable, clear, valid;
  logic [127:0] data;

  logic a_ready, a_busy, a_done, a_err_flag;
  logic [31:0] a_beat_cnt;
  logic [15:0] a_err_cnt;
  logic [127:0] a_first;
  logic b_ready, b_busy, b_done, b_err_flag;
  logic [31:0] b_beat_cnt;
  logic [15:0] b_err_cnt;
  logic [127:0] b_first;
  logic c_ready, c_busy, c_done, c_err_flag;
  logic [31:0] c_beat_cnt;
  logic [15:0] c_err_cnt;
  logic [127:0] c_first;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stream_seq_checker #(.NUM_BEATS(8)) dut_a (
    .clk(clk), .areset(areset), .enable(enable), .clear(clear), .valid(valid), .data(data),
    .ready(a_ready), .busy(a_busy), .done(a_done), .err_flag(a_err_flag),
    .beat_cnt(a_beat_cnt), .err_cnt(a_err_cnt), .first_err_got(a_first));

  stream_seq_checker #(.NUM_BEATS(0)) dut_b (
    .clk(clk), .areset(areset), .enable(enable), .clear(clear), .valid(valid), .data(data),
    .ready(b_ready), .busy(b_busy), .done(b_done), .err_flag(b_err_flag),
    .beat_cnt(b_beat_cnt), .err_cnt(b_err_cnt), .first_err_got(b_first));

  stream_seq_checker #(.NUM_BEATS(0), .STOP_ON_ERR(1)) dut_c (
    .clk(clk), .areset(areset), .enable(enable), .clear(clear), .valid(valid), .data(data),
    .ready(c_ready), .busy(c_busy), .done(c_done), .err_flag(c_err_flag),
    .beat_cnt(c_beat_cnt), .err_cnt(c_err_cnt), .first_err_got(c_first));

`ifdef STREAM_CHK_BP_EN
  logic d_ready, d_busy, d_done, d_err_flag;
  logic [31:0] d_beat_cnt;
  logic [15:0] d_err_cnt;
  logic [127:0] d_first;

  stream_seq_checker #(.NUM_BEATS(1000)) dut_d (
    .clk(clk), .areset(areset), .enable(enable), .clear(clear), .valid(valid), .data(data),
    .ready(d_ready), .busy(d_busy), .done(d_done), .err_flag(d_err_flag),
    .beat_cnt(d_beat_cnt), .err_cnt(d_err_cnt), .first_err_got(d_first));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] d);
    data  = d;
    valid = 1'b1;
    tick();
    $display("beat data=%0h a_rdy=%b b_cnt=%0d c_cnt=%0d", d, a_ready, b_beat_cnt, c_beat_cnt);
  endtask

  task automatic pulse_clear();
    enable = 1'b0;
    valid  = 1'b0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b1; clear = 1'b0; valid = 1'b1; data = 128'd5;
    tick();
    tick();
    vec++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", a_ready); end
    vec++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
    vec++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", a_done); end
    vec++; if (b_err_flag !== 1'b0) begin bad++; $display("FAIL reset_err_flag got %b want 0", b_err_flag); end
    vec++; if (b_err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err_cnt got %0d want 0", b_err_cnt); end
    vec++; if (b_first !== 128'd0) begin bad++; $display("FAIL reset_first got %0h want 0", b_first); end
    areset = 1'b0; enable = 1'b0; valid = 1'b0;
    tick();
    vec++; if (c_beat_cnt !== 32'd0) begin bad++; $display("FAIL reset_beat_cnt got %0d want 0", c_beat_cnt); end
    vec++; if (c_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got %b want 0", c_busy); end
  endtask

  task automatic test_run8();
    enable = 1'b1;
    tick();
    vec++; if (a_ready !== 1'b1) begin bad++; $display("FAIL run8_ready_rise got %b want 1", a_ready); end
    vec++; if (a_busy !== 1'b1) begin bad++; $display("FAIL run8_busy got %b want 1", a_busy); end
    for (int i = 0; i < 8; i++) beat(128'(5 + i));
    vec++; if (a_done !== 1'b1) begin bad++; $display("FAIL run8_done got %b want 1", a_done); end
    vec++; if (a_beat_cnt !== 32'd8) begin bad++; $display("FAIL run8_beat_cnt got %0d want 8", a_beat_cnt); end
    vec++; if (a_err_cnt !== 16'd0) begin bad++; $display("FAIL run8_err_cnt got %0d want 0", a_err_cnt); end
    vec++; if (a_ready !== 1'b0) begin bad++; $display("FAIL run8_ready_fall got %b want 0", a_ready); end
    beat(128'd13);
    vec++; if (a_beat_cnt !== 32'd8) begin bad++; $display("FAIL run8_no_extra got %0d want 8", a_beat_cnt); end
    vec++; if (b_beat_cnt !== 32'd9) begin bad++; $display("FAIL run8_free_cnt got %0d want 9", b_beat_cnt); end
    vec++; if (b_err_cnt !== 16'd0) begin bad++; $display("FAIL run8_free_err got %0d want 0", b_err_cnt); end
    // beat 14 presented together with clear must be dropped
    data = 128'd14; valid = 1'b1; clear = 1'b1; enable = 1'b0;
    tick();
    clear = 1'b0; valid = 1'b0;
    vec++; if (b_beat_cnt !== 32'd0) begin bad++; $display("FAIL clear_drop_beat got %0d want 0", b_beat_cnt); end
    vec++; if (a_done !== 1'b0) begin bad++; $display("FAIL clear_done got %b want 0", a_done); end
  endtask

  task automatic test_mismatch();
    enable = 1'b1;
    tick();
    beat(128'd0); beat(128'd1); beat(128'd2); beat(128'd7);
    vec++; if (b_err_cnt !== 16'd1) begin bad++; $display("FAIL mis_err_cnt got %0d want 1", b_err_cnt); end
    beat(128'd8);
    vec++; if (b_err_cnt !== 16'd1) begin bad++; $display("FAIL mis_resync got %0d want 1", b_err_cnt); end
    vec++; if (b_err_flag !== 1'b1) begin bad++; $display("FAIL mis_err_flag got %b want 1", b_err_flag); end
    vec++; if (b_first !== 128'd7) begin bad++; $display("FAIL mis_first got %0h want 7", b_first); end
    vec++; if (b_beat_cnt !== 32'd5) begin bad++; $display("FAIL mis_beat_cnt got %0d want 5", b_beat_cnt); end
    beat(128'd20);
    vec++; if (b_first !== 128'd7) begin bad++; $display("FAIL mis_first_sticky got %0h want 7", b_first); end
    vec++; if (b_err_cnt !== 16'd2) begin bad++; $display("FAIL mis_err_cnt2 got %0d want 2", b_err_cnt); end
    pulse_clear();
  endtask

  task automatic test_wrap();
    logic [127:0] top;
    top = '1;
    enable = 1'b1;
    tick();
    beat(top - 128'd1); beat(top); beat(128'd0); beat(128'd1);
    vec++; if (b_err_cnt !== 16'd0) begin bad++; $display("FAIL wrap_err_cnt got %0d want 0", b_err_cnt); end
    vec++; if (b_beat_cnt !== 32'd4) begin bad++; $display("FAIL wrap_beat_cnt got %0d want 4", b_beat_cnt); end
    vec++; if (b_err_flag !== 1'b0) begin bad++; $display("FAIL wrap_err_flag got %b want 0", b_err_flag); end
    enable = 1'b0; valid = 1'b0;
    tick();
    vec++; if (b_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", b_busy); end
    vec++; if (b_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got %b want 0", b_ready); end
    vec++; if (b_beat_cnt !== 32'd4) begin bad++; $display("FAIL idle_held got %0d want 4", b_beat_cnt); end
    pulse_clear();
  endtask

  task automatic test_stop();
    enable = 1'b1;
    tick();
    beat(128'd0); beat(128'd1); beat(128'd3);
    vec++; if (c_ready !== 1'b0) begin bad++; $display("FAIL stop_ready got %b want 0", c_ready); end
    vec++; if (c_busy !== 1'b0) begin bad++; $display("FAIL stop_busy got %b want 0", c_busy); end
    vec++; if (c_beat_cnt !== 32'd3) begin bad++; $display("FAIL stop_beat_cnt got %0d want 3", c_beat_cnt); end
    vec++; if (c_first !== 128'd3) begin bad++; $display("FAIL stop_first got %0h want 3", c_first); end
    beat(128'd4);
    vec++; if (c_beat_cnt !== 32'd3) begin bad++; $display("FAIL stop_no_accept got %0d want 3", c_beat_cnt); end
    vec++; if (b_beat_cnt !== 32'd4) begin bad++; $display("FAIL stop_free_runs got %0d want 4", b_beat_cnt); end
    pulse_clear();
    vec++; if (c_beat_cnt !== 32'd0) begin bad++; $display("FAIL stop_clr_cnt got %0d want 0", c_beat_cnt); end
    vec++; if (c_err_cnt !== 16'd0) begin bad++; $display("FAIL stop_clr_err got %0d want 0", c_err_cnt); end
    vec++; if (c_err_flag !== 1'b0) begin bad++; $display("FAIL stop_clr_flag got %b want 0", c_err_flag); end
    vec++; if (c_first !== 128'd0) begin bad++; $display("FAIL stop_clr_first got %0h want 0", c_first); end
    enable = 1'b1;
    tick();
    vec++; if (c_ready !== 1'b1) begin bad++; $display("FAIL stop_restart got %b want 1", c_ready); end
    pulse_clear();
  endtask

`ifdef STREAM_CHK_BP_EN
  task automatic test_backpressure();
    logic [15:0]  lfsr_m;
    logic [127:0] cnt;
    logic         r, bz;
    int           cyc;
    pulse_clear();
    lfsr_m = 16'hACE1;
    cnt    = '0;
    cyc    = 0;
    enable = 1'b1;
    valid  = 1'b1;
    data   = cnt;
    while (d_done !== 1'b1 && cyc < 20000) begin
      r  = d_ready;
      bz = d_busy;
      tick();
      cyc++;
      if (bz) lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      if (r) cnt = cnt + 128'd1;
      else   cnt = '0;
      data = cnt;
      vec++;
      if (d_ready !== (d_busy && lfsr_m[0])) begin
        bad++;
        $display("FAIL bp_ready cyc=%0d got %b want %b", cyc, d_ready, d_busy && lfsr_m[0]);
      end
    end
    $display("bp run ended after %0d cycles beat_cnt=%0d", cyc, d_beat_cnt);
    vec++; if (d_done !== 1'b1) begin bad++; $display("FAIL bp_done got %b want 1", d_done); end
    vec++; if (d_err_cnt !== 16'd0) begin bad++; $display("FAIL bp_err_cnt got %0d want 0", d_err_cnt); end
    vec++; if (d_beat_cnt !== 32'd1000) begin bad++; $display("FAIL bp_beat_cnt got %0d want 1000", d_beat_cnt); end
    pulse_clear();
  endtask
`endif

  initial begin
    test_reset();
`ifdef STREAM_CHK_BP_EN
    test_backpressure();
`else
    test_run8();
    test_mismatch();
    test_wrap();
    test_stop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/stream_seq_checker.md
Name: stream_seq_checker

Overview:
- Sink and checker for the incrementing 128-bit count stream produced by the traffic counter source.
- Drives the ready handshake back to the source and accepts beats.
- Verifies each accepted beat equals the previous accepted beat + 1, modulo 2^DATA_W.
- Reports beat count, error count and the first mismatching value; serves as the receive end of the bridge self-test path.

Parameters:
- DATA_W, 128, width of data beat
- NUM_BEATS, 1024, beats to accept per run before done; 0 = run until enable drops
- ERR_W, 16, width of saturating error counter
- STOP_ON_ERR, 0, 1 = halt (ready low) on first mismatch

Ports:
- clk  in  1  clock
- areset  in  1  synchronous reset, active-high
- enable  in  1  start/continue run; level
- clear  in  1  one-cycle pulse: zero counters/flags, return to IDLE
- valid  in  1  source beat valid
- data  in  DATA_W  source beat (count value)
- ready  out  1  sink ready to source
- busy  out  1  high in SYNC or CHECK
- done  out  1  sticky, run completed
- err_flag  out  1  sticky, at least one mismatch
- beat_cnt  out  32  accepted beats this run
- err_cnt  out  ERR_W  mismatches, saturating at all-ones
- first_err_got  out  DATA_W  data of first mismatching beat

Behaviour:
- Reset (areset=1 at clk edge):
  - state=IDLE; ready=0, busy=0, done=0, err_flag=0, beat_cnt=0, err_cnt=0, first_err_got=0, expected=0.
  - Reset mid-run aborts the run with no further beats accepted.
- Accept: a beat is accepted iff valid && ready at a clk edge. ready is registered and depends only on state (plus backpressure when the optional feature is enabled).
- States:
  - IDLE: ready=0. enable=1 -> SYNC.
  - SYNC: ready=1. First accepted beat: no compare; expected <= data+1; beat_cnt <= 1; go to CHECK. enable=0 -> IDLE.
  - CHECK: ready=1. On each accepted beat: beat_cnt++.
    - Match (data == expected): expected <= data+1, wrapping all-ones -> 0 without error.
    - Mismatch: err_cnt++ (saturating); err_flag <= 1; first_err_got <= data only if err_flag was 0; expected <= data+1 (resync). If STOP_ON_ERR=1 -> HALT.
    - When the beat making beat_cnt == NUM_BEATS is accepted (NUM_BEATS != 0): done <= 1 same edge; next state DONE.
    - enable=0 with no beat accepted that cycle -> IDLE, counters held.
  - DONE: ready=0; holds all outputs until clear or areset.
  - HALT: ready=0; holds all outputs until clear or areset.
- Timing:
  - ready rises the cycle after the state enters SYNC (registered); 1-cycle latency from enable to ready.
  - ready falls the cycle after the terminating beat; the source sees at most one beat accepted after the decision edge, and it is already counted.
- Source stall: valid=0 in CHECK is legal, with no compare and expected held. The source restarts at 0 after any ready-low cycle. Therefore every IDLE/backpressure exit that deasserted ready reloads via SYNC, not CHECK.
- clear has priority over all state activity except areset: same-edge zeroing of all counters/flags, state <= IDLE, ready <= 0.
- Simultaneous clear and accepted beat: the beat is dropped, not counted.
- beat_cnt wraps at 2^32 without flag (NUM_BEATS=0 only).
- busy = (state==SYNC || state==CHECK), registered.

Optional Feature:
- Macro: STREAM_CHK_BP_EN.
- Defined:
  - 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11, advances every cycle in SYNC/CHECK.
  - ready = state-ready && lfsr[0].
  - Any cycle with ready=0 from backpressure forces a return to SYNC behaviour: the next accepted beat reloads expected with no compare.
  - The LFSR resets to seed on areset/clear.
- Undefined: no LFSR; ready is constant 1 in SYNC/CHECK.

Test Plan:
- areset=1 for 2 cycles with valid=1 -> ready=0, all counters 0, state IDLE; no beat accepted.
- NUM_BEATS=8, enable=1, source drives 5,6,...,12 with valid=1 -> beat_cnt=8, err_cnt=0, done=1 the edge after the 8th beat, ready=0 next cycle.
- Stream 0,1,2,7,8 (NUM_BEATS=0) -> err_cnt=1, err_flag=1, first_err_got=7, beat_cnt=5; beat 8 counts as match after resync.
- Wrap: stream 2^128-2, 2^128-1, 0, 1 -> err_cnt=0, beat_cnt=4.
- STOP_ON_ERR=1, stream 0,1,3,4 -> HALT after beat 3, ready=0 next cycle, beat_cnt=3, beat 4 not accepted; clear pulse -> IDLE with all counters 0.
- STREAM_CHK_BP_EN defined, connected to the counter source, NUM_BEATS=1000 -> err_cnt=0, done=1; ready low on cycles where lfsr[0]=0 against reference LFSR model.
